// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ char sources; it also times each frame.
// Define UART_TX_ARB_PRIO_EN to make requester 0 urgent (wins whenever it asks, pointer untouched).
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FRAME_BITS = 10,
  parameter int START_HOLD = 1,
  parameter int GAP        = 1
) (
  input  logic               clk1x_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [7*N_REQ-1:0] din_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic [N_REQ-1:0]   done_o,
  output logic               busy_o,
  output logic               tx_mode_o,
  output logic               tx_start_o,
  output logic [6:0]         tx_din_o
);
  localparam int PW   = $clog2(N_REQ);
  localparam int CMAX = (FRAME_BITS > GAP) ? FRAME_BITS : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_FRAME, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d, win_q, win_d, win;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic             tx_start_q, tx_start_d, busy_q, found;
  logic [6:0]       tx_din_q, tx_din_d;

  // First requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_i[(int'(ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
`ifdef UART_TX_ARB_PRIO_EN
    if (req_i[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    done_d     = '0;
    tx_start_d = tx_start_q;
    tx_din_d   = tx_din_q;
    case (state_q)
      S_IDLE: begin
        tx_start_d = 1'b0;
        cnt_d      = '0;
        if (found) begin
          gnt_d[win] = 1'b1;
          tx_din_d   = din_i[7*int'(win) +: 7];
          tx_start_d = 1'b1;
          win_d      = win;
          cnt_d      = CW'(1);
          state_d    = S_START;
`ifdef UART_TX_ARB_PRIO_EN
          if (!req_i[0]) ptr_d = PW'((int'(win) + 1) % N_REQ);
`else
          ptr_d = PW'((int'(win) + 1) % N_REQ);
`endif
        end
      end
      S_START, S_FRAME: begin
        // cnt_q is the 1-based cycle index since tx_start rose.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(START_HOLD)) begin
          tx_start_d = 1'b0;
          state_d    = S_FRAME;
        end
        if (cnt_q == CW'(FRAME_BITS)) begin
          done_d[win_q] = 1'b1;
          tx_start_d    = 1'b0;
          if (GAP == 0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_GAP;
            cnt_d   = CW'(1);
          end
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk1x_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign busy_o     = busy_q;
  assign tx_mode_o  = 1'b1;
  assign tx_start_o = tx_start_q;
  assign tx_din_o   = tx_din_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized + directed bench for uart_tx_arbiter; a transaction-level model feeds gnt/done
// scoreboards that a negedge monitor drains.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int FB = 10;
  localparam int SH = 1;
  localparam int GP = 1;

  logic           clk = 1'b0, rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] din = '0;
  logic [N-1:0]   gnt_o, done_o;
  logic           busy_o, tx_mode_o, tx_start_o;
  logic [6:0]     tx_din_o;

  uart_tx_arbiter #(.N_REQ(N), .FRAME_BITS(FB), .START_HOLD(SH), .GAP(GP)) dut (
    .clk1x_i(clk), .rst_i(rst), .req_i(req), .din_i(din),
    .gnt_o(gnt_o), .done_o(done_o), .busy_o(busy_o), .tx_mode_o(tx_mode_o),
    .tx_start_o(tx_start_o), .tx_din_o(tx_din_o));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a transaction occupies the line from its grant cycle T
  // for FB+GP cycles; a new grant may be issued once the line is free.
  typedef struct { int c; int w; } ev_t;
  ev_t        gq[$], dq[$];
  int         ptr = 0, free_at = 0, t_last = -1000;
  logic [6:0] m_din = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      ptr = 0; free_at = cyc + 1; t_last = -1000; m_din = '0;
      gq.delete(); dq.delete();
    end else if (cyc >= free_at && req != '0) begin
      int w;
      bit prio;
      w = -1;
      prio = 1'b0;
`ifdef UART_TX_ARB_PRIO_EN
      if (req[0]) begin w = 0; prio = 1'b1; end
`endif
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(ptr + k) % N]) w = (ptr + k) % N;
      if (!prio) ptr = (w + 1) % N;
      m_din = din[7*w +: 7];
      gq.push_back('{cyc, w});
      dq.push_back('{cyc + FB, w});
      t_last = cyc;
      free_at = cyc + FB + GP + 1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("tx_mode", int'(tx_mode_o), 1);
      chk("busy", int'(busy_o), int'(cyc >= t_last && cyc < t_last + FB + GP));
      chk("tx_start", int'(tx_start_o), int'(cyc >= t_last && cyc < t_last + SH));
      chk("tx_din", int'(tx_din_o), int'(m_din));
      if (gnt_o != '0 || (gq.size() > 0 && gq[0].c == cyc)) begin
        if (gq.size() == 0) chk("gnt_unexpected", int'(gnt_o), 0);
        else begin
          ev_t e;
          e = gq.pop_front();
          chk("gnt_cycle", cyc, e.c);
          chk("gnt_vec", int'(gnt_o), 1 << e.w);
        end
      end
      if (done_o != '0 || (dq.size() > 0 && dq[0].c == cyc)) begin
        if (dq.size() == 0) chk("done_unexpected", int'(done_o), 0);
        else begin
          ev_t e;
          e = dq.pop_front();
          chk("done_cycle", cyc, e.c);
          chk("done_vec", int'(done_o), 1 << e.w);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(output int w, output int c);
    w = -1; c = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (gnt_o != '0) begin w = $clog2(gnt_o); c = cyc; break; end
    end
    if (w < 0) chk("gnt_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy_o; i++) step();
    chk("idle_timeout", int'(busy_o), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  int w, c, pc;
  logic [6:0] old;

  initial begin
    // reset held two edges with all requests up
    req = '1; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    wait_gnt(w, c); chk("t1_first", w, 0);
    req = '0; wait_idle();

    // single requester
    din[20:14] = 7'h55; req = 4'b0100;
    wait_gnt(w, c); chk("t2_w", w, 2); chk("t2_din", int'(tx_din_o), 'h55);
    req = '0; wait_idle();

    // fairness
    do_reset(); req = '1; pc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(w, c);
      chk("t3_order", w, k % N);
      if (k > 0) chk("t3_spacing", c - pc, FB + GP + 1);
      pc = c;
    end
    req = '0; wait_idle();

    // withdraw / ignore / din not resampled
    din = 28'h1234567; req = 4'b0001;
    wait_gnt(w, c); req = '0;
    old = din[6:0]; din[6:0] = ~old;
    step(); step(); req[1] = 1'b1; step(); req[1] = 1'b0; req[3] = 1'b1;
    chk("t4_din_hold", int'(tx_din_o), int'(old));
    wait_gnt(w, c); chk("t4_w", w, 3); req = '0; wait_idle();

    // reset mid-frame
    req = 4'b0100;
    wait_gnt(w, c); req = '0;
    repeat (4) step();
    do_reset();
    chk("t5_busy", int'(busy_o), 0); chk("t5_start", int'(tx_start_o), 0);
    req = '1; wait_gnt(w, c); chk("t5_ptr0", w, 0); req = '0; wait_idle();

    // requester 0 priority (or plain round-robin without the macro)
    do_reset(); req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(w, c);
`ifdef UART_TX_ARB_PRIO_EN
      chk("t6_prio", w, 0);
`else
      chk("t6_rr", w, (k % 2) ? 3 : 0);
`endif
    end
    req = '0; wait_idle();
    do_reset(); req = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      wait_gnt(w, c); chk("t6_1110", w, k + 1); req &= ~gnt_o;
    end
    req = '0; wait_idle();

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 399) == 0);
      req &= ~gnt_o;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = 1'b1;
        else if ($urandom_range(0, 15) == 0) req[b] = 1'b0;
      end
      din = 28'($urandom);
    end
    rst = 1'b0; req = '0;
    repeat (30) step();
    chk("drain", gq.size() + dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
